// File: rtl/common_pkg.sv
// Shared types and defaults for the datapath-sharing blocks.
package common_pkg;

   localparam int TEST_PARAM = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic busy;
      logic timeout;
   } arb_status_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search starting at ptr, wrapping at N_REQ-1 (any N_REQ).
module rr_pick #(
   parameter int N_REQ = 3
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] ptr,
   output logic                     valid,
   output logic [$clog2(N_REQ)-1:0] idx
);

   localparam int IDX_W = $clog2(N_REQ);

   int cand;

   // Scan farthest offset first so the nearest hit to ptr is the last write.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      cand  = 0;
      for (int off = N_REQ - 1; off >= 0; off--) begin
         cand = int'(ptr) + off;
         if (cand >= N_REQ) cand = cand - N_REQ;
         if (req[cand]) begin
            valid = 1'b1;
            idx   = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/rr_res_arbiter.sv
// Round-robin arbiter for a single-port shared resource, with a hold limit on contested grants.
module rr_res_arbiter
   import common_pkg::*;
#(
   parameter int N_REQ    = TEST_PARAM,
   parameter int MAX_HOLD = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [N_REQ-1:0]         req_i,
   output logic [N_REQ-1:0]         gnt_o,
   output logic [$clog2(N_REQ)-1:0] sel_o,
   output logic                     en_o,
   output logic                     busy_o,
   output logic                     timeout_o
);

   localparam int IDX_W  = $clog2(N_REQ);
   localparam int HOLD_W = $clog2(MAX_HOLD + 1);

   arb_state_t       state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [IDX_W-1:0] sel_q, sel_d;
   logic             en_q, en_d;
   arb_status_t      stat_q, stat_d;

   logic             pick_vld;
   logic [IDX_W-1:0] pick_idx;
   logic             hold_max;
   logic             others_req;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req   (req_i),
      .ptr   (ptr_q),
      .valid (pick_vld),
      .idx   (pick_idx)
   );

   assign hold_max   = (hold_q == HOLD_W'(MAX_HOLD));
   assign others_req = |(req_i & ~gnt_q);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      hold_d  = hold_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      en_d    = en_q;
      stat_d  = '0;
      unique case (state_q)
         IDLE: begin
            if (pick_vld) begin
               gnt_d           = '0;
               gnt_d[pick_idx] = 1'b1;
               sel_d           = pick_idx;
               en_d            = 1'b1;
               hold_d          = HOLD_W'(1);
               state_d         = GRANT;
            end
         end
         GRANT: begin
            // Grantee drop wins over timeout, so it is tested first.
            if (!req_i[sel_q]) begin
               gnt_d   = '0;
               en_d    = 1'b0;
               state_d = RELEASE;
            end else if (hold_max && others_req) begin
               gnt_d          = '0;
               en_d           = 1'b0;
               stat_d.timeout = 1'b1;
               state_d        = RELEASE;
            end else if (!hold_max) begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         RELEASE: begin
            ptr_d   = (sel_q == IDX_W'(N_REQ - 1)) ? '0 : sel_q + IDX_W'(1);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      stat_d.busy = (state_d != IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         hold_q  <= '0;
         gnt_q   <= '0;
         sel_q   <= '0;
         en_q    <= 1'b0;
         stat_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         en_q    <= en_d;
         stat_q  <= stat_d;
      end
   end

   assign gnt_o     = gnt_q;
   assign sel_o     = sel_q;
   assign en_o      = en_q;
   assign busy_o    = stat_q.busy;
   assign timeout_o = stat_q.timeout;

endmodule

// File: doc/rr_res_arbiter.md
# rr_res_arbiter

Round-robin arbiter and sequencer that shares one single-port datapath resource between `N_REQ` requesters. It issues a registered one-hot grant and drives the resource's index select (`$clog2(TEST_PARAM)` bits wide) and enable. It also enforces a maximum hold time, so one requester cannot starve the others. It sits directly in front of the shared resource, alongside the other blocks built on `common_pkg`.

## Interface
- `N_REQ`, default `TEST_PARAM` (from `common_pkg`): number of requesters; must be ≥2 and need not be a power of two.
- `MAX_HOLD`, default 8: maximum number of grant cycles before a contested grant is revoked; must be ≥1.
- `IDX_W` (localparam): `$clog2(N_REQ)`, the width of the select index.
- Clocking: one clock; reset is synchronous and active-high.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `req_i`  in  `N_REQ`  per-requester level request; held high while the requester needs the resource.
- `gnt_o`  out  `N_REQ`  registered grant; one-hot or zero.
- `sel_o`  out  `IDX_W`  index of the current or last grantee; drives the resource's index input.
- `en_o`  out  1  resource enable; high exactly when `gnt_o` is non-zero.
- `busy_o`  out  1  high when the FSM is not in IDLE.
- `timeout_o`  out  1  single-cycle pulse when a grant is revoked by `MAX_HOLD`.

## Operation
- FSM states: IDLE, GRANT, RELEASE (enum `arb_state_t`).
- Round-robin pointer `ptr` (width `IDX_W`) marks the highest-priority index. Search order is `ptr`, `ptr+1`, … , `N_REQ-1`, 0, … , `ptr-1`.
- **IDLE**
  - If `req_i` is non-zero, pick the winner by the search order.
  - Register `gnt_o` = one-hot(winner), `sel_o` = winner, `en_o` = 1, `hold_cnt` = 1.
  - Go to GRANT.
  - If `req_i` is zero, stay in IDLE; `sel_o` keeps its last value.
- **GRANT**
  - If `req_i[sel_o]` is 0: go to RELEASE.
  - Else if `hold_cnt == MAX_HOLD` and any other request is pending: go to RELEASE and pulse `timeout_o` for 1 cycle, coincident with the first RELEASE cycle.
  - Else if `hold_cnt == MAX_HOLD` and no other request is pending: stay in GRANT; `hold_cnt` saturates at `MAX_HOLD`.
  - Otherwise: increment `hold_cnt`.
  - A requester drop takes precedence over timeout; no `timeout_o` pulse when both occur in the same cycle.
- **RELEASE**
  - `gnt_o` = 0, `en_o` = 0 for exactly one turnaround cycle.
  - `ptr` = `sel_o`+1, wrapping from `N_REQ-1` to 0 with an explicit compare (no modulo-2^`IDX_W` reliance).
  - Go to IDLE unconditionally.
- Requests for indices other than the grantee are ignored during GRANT and RELEASE; they are only evaluated in IDLE.
- `hold_cnt` width is `$clog2(MAX_HOLD+1)`; it never overflows.

## Timing
- Reset values: `gnt_o`=0, `sel_o`=0, `en_o`=0, `busy_o`=0, `timeout_o`=0, `ptr`=0, `hold_cnt`=0, state=IDLE.
- Grant latency:
  - `req_i` sampled high at edge k in IDLE → `gnt_o`/`en_o` high from edge k+1.
  - Grantee drops `req_i` before edge m → `gnt_o` low from edge m+1 (RELEASE).
  - Next grant earliest at edge m+3 (RELEASE → IDLE → GRANT).
- Hold limit: a contested grant lasts exactly `MAX_HOLD` cycles.
- `busy_o` is registered and equals (state != IDLE).
- `rst_i` asserted in any state → all outputs at reset values after that edge, regardless of `req_i`. No partial grant survives reset.
- `en_o`, `gnt_o`, `sel_o`, `timeout_o` come straight from flops; no combinational path from `req_i` to any output.

## Structure
- `common_pkg` holds the `arb_state_t` enum and a packed status struct `arb_status_t` (`busy`, `timeout`), alongside the existing types. `TEST_PARAM` stays the default source for `N_REQ`.
- One sub-module: `rr_pick`. It is combinational and takes `req`, `ptr` and returns `valid` and `idx` for a round-robin search over a non-power-of-two `N_REQ`. It is instantiated once in IDLE-path logic.
- Top level holds the FSM, `ptr`, `hold_cnt`, and the output registers.

## Test plan
- **Single requester** (`N_REQ`=3): `req_i`=3'b010 from cycle 2 → `gnt_o`=3'b010, `sel_o`=1, `en_o`=1 from cycle 3. Drop at cycle 6 → `gnt_o`=0 at cycle 7.
- **Simultaneous requests after reset:** `req_i`=3'b101 held → grant index 0 first. After a drop or timeout, index 2 is granted 2 cycles after RELEASE, not index 0.
- **Timeout** (`MAX_HOLD`=4): `req_i`=3'b011 held continuously → index 0 gets exactly 4 grant cycles, `timeout_o` pulses once, then index 1 is granted. Grants alternate indefinitely.
- **Uncontested hold:** only index 1 requests for 20 cycles with `MAX_HOLD`=4 → grant stays continuous and `timeout_o` never pulses.
- **Wrap-around** (`N_REQ`=3): grant index 2, release with `req_i`=3'b011 → next grant is index 0.
- **Reset mid-grant:** `rst_i` high for 1 cycle during GRANT with `req_i` still high → all outputs 0 and `ptr`=0 the next cycle. The re-grant goes to the lowest pending index, 2 cycles after `rst_i` falls.
